per2apb_bridge: RTL and testbench
=================================

Name: per2apb_bridge

Overview:
Peripheral-interconnect slave to APB master bridge on the SoC peripheral bus. It accepts one single-beat per-interconnect request at a time, replays it as an APB setup/access transfer, and returns the completion on the per response channel. It is the downstream counterpart of the APB-to-per adapter, so APB peripherals can hang off the per interconnect. A timeout counter keeps a hung APB target from locking the interconnect.

Parameters:
PER_ADDR_WIDTH, 32, width of per_slave_add_i
APB_ADDR_WIDTH, 32, width of PADDR (PADDR = add[APB_ADDR_WIDTH-1:0], zero-extended if wider than PER_ADDR_WIDTH)
TIMEOUT_CYCLES, 256, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
per_slave_req_i  input  1  request valid
per_slave_add_i  input  PER_ADDR_WIDTH  byte address
per_slave_we_i  input  1  1=write, 0=read
per_slave_wdata_i  input  32  write data
per_slave_be_i  input  4  byte enables
per_slave_gnt_o  output  1  request accepted this cycle
per_slave_r_valid_o  output  1  response valid, one-cycle pulse
per_slave_r_opc_o  output  1  1=error (PSLVERR or timeout)
per_slave_r_rdata_o  output  32  read data
PADDR  output  APB_ADDR_WIDTH  APB address
PWDATA  output  32  APB write data
PWRITE  output  1  APB direction
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PSTRB  output  4  APB4 write strobes
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Reset: state IDLE; PSEL, PENABLE, PWRITE, r_valid, r_opc = 0; PADDR, PWDATA, PSTRB, r_rdata = 0; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- gnt_o is combinational: gnt_o = req_i && state==IDLE. It never asserts in any other state.
- IDLE: on req_i=1, latch addr, we, wdata, be into PADDR, PWRITE, PWDATA, PSTRB, then go to SETUP.
  - PSTRB = be for writes, 4'b0000 for reads.
  - PWDATA = 0 for reads.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA, PSTRB are held stable.
  - PREADY=1: deassert PSEL and PENABLE next cycle and go to RESP.
    - Read: r_rdata <= PRDATA.
    - Write: r_rdata <= 0.
    - r_opc <= PSLVERR.
  - Timeout: counter increments each ACCESS cycle with PREADY=0. When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with PREADY=0, abort: deassert PSEL and PENABLE, r_opc <= 1, r_rdata <= 0, go to RESP.
  - PREADY=1 on the terminal count cycle counts as a normal completion, not a timeout.
  - Counter clears on entry to SETUP.
- RESP: r_valid_o=1 for exactly one cycle with r_opc/r_rdata valid, then go to IDLE. r_opc/r_rdata hold their values until the next completion.
- Latency:
  - Grant in cycle T; SETUP T+1; ACCESS from T+2.
  - PREADY in cycle T+2+k gives r_valid at T+3+k.
  - Minimum request-to-request spacing is 4 cycles.
- Outputs besides gnt_o are registered; the APB side carries no combinational path from per inputs.
- The response channel has no backpressure; the master must accept r_valid in its pulse cycle.
- PREADY and PSLVERR are ignored outside ACCESS. PRDATA is sampled only on a completing read.
- Async reset mid-transfer: all outputs return to reset values immediately, the in-flight transfer is dropped, and no r_valid is produced.

Test Plan:
- Write, zero wait: req add=0x1A10_0004 we=1 wdata=0xCAFE_F00D be=0xF, PREADY=1 in first ACCESS.
  → gnt at T; PSEL=1/PENABLE=0 at T+1; PENABLE=1 PADDR=0x1A10_0004 PSTRB=0xF at T+2; r_valid=1 r_opc=0 r_rdata=0 at T+3.
- Read, 2 wait states: read add=0x10, PREADY low 2 ACCESS cycles, then high with PRDATA=0x1234_5678.
  → PSTRB=0; r_valid at T+5 with r_rdata=0x1234_5678; address/control stable throughout ACCESS.
- Slave error: read with PREADY=1 PSLVERR=1 PRDATA=0xFFFF_FFFF.
  → r_opc=1, r_rdata=0xFFFF_FFFF.
- Timeout: TIMEOUT_CYCLES=4, PREADY tied low.
  → PSEL drops after the 4th ACCESS cycle; r_valid=1 r_opc=1 r_rdata=0 next cycle.
  - Repeat with PREADY=1 on the 4th ACCESS cycle → normal completion, r_opc=0.
- Back-to-back: req held high for 2 reads.
  → gnt only in IDLE cycles, 4 cycles apart; 2 r_valid pulses in order with the correct data.
- Reset mid-op: assert rst_ni=0 during ACCESS.
  → PSEL/PENABLE=0 immediately; no r_valid; after release, next request completes normally.

Source files
------------

// File: rtl/per2apb_bridge.sv
// per2apb_bridge
// Single-beat peripheral-interconnect slave replayed as an APB4 master
// transfer (SETUP then ACCESS), with the completion returned on the per
// response channel. A down-count-free access timer aborts transfers to an
// APB target that never raises PREADY, so the interconnect cannot lock up.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a per request; grant is given here only
// SETUP  | APB setup phase: PSEL=1, PENABLE=0 for one cycle
// ACCESS | APB access phase: PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | one-cycle r_valid pulse carrying r_opc / r_rdata

module per2apb_bridge #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    // per interconnect slave side
    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [31:0]               per_slave_r_rdata_o,

    // APB master side
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [3:0]                PSTRB,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // The counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q, state_d;

    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [3:0]                pstrb_q, pstrb_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;

    logic                      rvalid_q, rvalid_d;
    logic                      ropc_q, ropc_d;
    logic [31:0]               rdata_q, rdata_d;

    logic [CNT_W-1:0]          cnt_q, cnt_d;

    // Address mapped onto the APB bus: truncated or zero-extended.
    logic [APB_ADDR_WIDTH-1:0] add_apb;
    assign add_apb = APB_ADDR_WIDTH'(per_slave_add_i);

    // Terminal count of the access timer, only meaningful while in ACCESS.
    logic                      timeout_hit;
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // Grant is the only combinational output: accept only when idle.
    assign per_slave_gnt_o = per_slave_req_i && (state_q == IDLE);

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = 1'b0;
        ropc_d    = ropc_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (per_slave_req_i) begin
                    paddr_d   = add_apb;
                    pwrite_d  = per_slave_we_i;
                    // Reads drive neither data nor strobes onto the bus.
                    pwdata_d  = per_slave_we_i ? per_slave_wdata_i : 32'h0;
                    pstrb_d   = per_slave_we_i ? per_slave_be_i : 4'h0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    // A ready on the terminal-count cycle still completes normally.
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    ropc_d    = PSLVERR;
                    rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    ropc_d    = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = RESP;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; async reset drops any in-flight transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // APB-side output registers; nothing from the per inputs reaches APB combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q   <= '0;
            pwdata_q  <= 32'h0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= 4'h0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // Response registers; opc/rdata persist until the next completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            ropc_q   <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= rvalid_d;
            ropc_q   <= ropc_d;
            rdata_q  <= rdata_d;
        end
    end

    assign PADDR               = paddr_q;
    assign PWDATA              = pwdata_q;
    assign PWRITE              = pwrite_q;
    assign PSTRB               = pstrb_q;
    assign PSEL                = psel_q;
    assign PENABLE             = penable_q;
    assign per_slave_r_valid_o = rvalid_q;
    assign per_slave_r_opc_o   = ropc_q;
    assign per_slave_r_rdata_o = rdata_q;

endmodule

// File: tb/tb_per2apb_bridge.sv
// Directed bench for per2apb_bridge with a transaction-level reference model
// (grant cycle / completion cycle bookkeeping) checked every cycle.

module tb_per2apb_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    per2apb_bridge #(
        .PER_ADDR_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .per_slave_req_i     (req),
        .per_slave_add_i     (add),
        .per_slave_we_i      (we),
        .per_slave_wdata_i   (wdata),
        .per_slave_be_i      (be),
        .per_slave_gnt_o     (gnt),
        .per_slave_r_valid_o (r_valid),
        .per_slave_r_opc_o   (r_opc),
        .per_slave_r_rdata_o (r_rdata),
        .PADDR               (paddr),
        .PWDATA              (pwdata),
        .PWRITE              (pwrite),
        .PSEL                (psel),
        .PENABLE             (penable),
        .PSTRB               (pstrb),
        .PRDATA              (prdata),
        .PREADY              (pready),
        .PSLVERR             (pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a transfer is described by its grant cycle tg and its
    // decision cycle td (last ACCESS cycle). Outputs follow from those numbers.
    initial begin : model
        int          cyc;
        bit          inflight;
        int          tg;
        int          td;
        logic [31:0] m_paddr, m_pwdata, m_rdata;
        logic        m_pwrite, m_opc;
        logic [3:0]  m_pstrb;
        logic        e_gnt, e_psel, e_pen, e_rv;

        cyc = 0; inflight = 0; tg = 0; td = -1;
        m_paddr = '0; m_pwdata = '0; m_rdata = '0;
        m_pwrite = 0; m_opc = 0; m_pstrb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 0; td = -1;
                m_paddr = '0; m_pwdata = '0; m_rdata = '0;
                m_pwrite = 0; m_opc = 0; m_pstrb = '0;
            end
            e_gnt  = req && !inflight;
            e_psel = inflight && (cyc >= tg + 1) && (td < 0 || cyc <= td);
            e_pen  = inflight && (cyc >= tg + 2) && (td < 0 || cyc <= td);
            e_rv   = inflight && (td >= 0) && (cyc == td + 1);

            chk("m_gnt",     gnt,     e_gnt);
            chk("m_psel",    psel,    e_psel);
            chk("m_penable", penable, e_pen);
            chk("m_rvalid",  r_valid, e_rv);
            chk("m_paddr",   paddr,   m_paddr);
            chk("m_pwdata",  pwdata,  m_pwdata);
            chk("m_pwrite",  pwrite,  m_pwrite);
            chk("m_pstrb",   pstrb,   m_pstrb);
            chk("m_ropc",    r_opc,   m_opc);
            chk("m_rdata",   r_rdata, m_rdata);

            if (rst_n) begin
                if (!inflight) begin
                    if (req) begin
                        inflight = 1; tg = cyc; td = -1;
                        m_paddr  = add;
                        m_pwrite = we;
                        m_pwdata = we ? wdata : 32'h0;
                        m_pstrb  = we ? be : 4'h0;
                    end
                end else if (td < 0) begin
                    if (cyc >= tg + 2) begin
                        if (pready) begin
                            td = cyc;
                            m_opc = pslverr;
                            m_rdata = m_pwrite ? 32'h0 : prdata;
                        end else if (cyc - (tg + 2) == TO - 1) begin
                            td = cyc;
                            m_opc = 1'b1;
                            m_rdata = 32'h0;
                        end
                    end
                end else if (cyc == td + 1) begin
                    inflight = 0;
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) step();
        chk("rst psel", psel, 1'b0);
        chk("rst paddr", paddr, 32'h0);
        chk("rst rvalid", r_valid, 1'b0);
        rst_n = 1'b1;
        step();

        // Write, zero wait states (PREADY already high during SETUP is ignored)
        step(); req = 1; add = 32'h1A10_0004; we = 1; wdata = 32'hCAFE_F00D; be = 4'hF;
        #1 chk("wr gnt T", gnt, 1'b1);
        step(); req = 0; pready = 1;
        #1 chk("wr psel T+1", psel, 1'b1); chk("wr penable T+1", penable, 1'b0);
        step();
        #1 chk("wr penable T+2", penable, 1'b1); chk("wr paddr T+2", paddr, 32'h1A10_0004);
        chk("wr pstrb T+2", pstrb, 4'hF);
        step(); pready = 0;
        #1 chk("wr rvalid T+3", r_valid, 1'b1); chk("wr ropc T+3", r_opc, 1'b0);
        chk("wr rdata T+3", r_rdata, 32'h0);
        step();

        // Read, two wait states
        step(); req = 1; add = 32'h0000_0010; we = 0; wdata = 32'hDEAD_BEEF; be = 4'hF;
        step(); req = 0;
        step();
        #1 chk("rd pstrb", pstrb, 4'h0); chk("rd pwdata", pwdata, 32'h0);
        step();
        step(); pready = 1; prdata = 32'h1234_5678;
        step(); pready = 0; prdata = 32'h0;
        #1 chk("rd rvalid T+5", r_valid, 1'b1); chk("rd rdata T+5", r_rdata, 32'h1234_5678);
        step();

        // Slave error on a read
        step(); req = 1; add = 32'h0000_0080; we = 0;
        step(); req = 0; pready = 1; pslverr = 1; prdata = 32'hFFFF_FFFF;
        step();
        step(); pready = 0; pslverr = 0; prdata = 32'h0;
        #1 chk("err ropc", r_opc, 1'b1); chk("err rdata", r_rdata, 32'hFFFF_FFFF);
        step();

        // Timeout: PREADY never rises, read data on the bus must not leak through
        step(); req = 1; add = 32'h0000_0100; we = 0; prdata = 32'h7777_7777;
        step(); req = 0;
        step(); step(); step(); step();
        #1 chk("to psel 4th access", psel, 1'b1);
        step();
        #1 chk("to psel dropped", psel, 1'b0); chk("to rvalid", r_valid, 1'b1);
        chk("to ropc", r_opc, 1'b1); chk("to rdata", r_rdata, 32'h0);
        step();

        // PREADY on the terminal-count cycle completes normally
        step(); req = 1; add = 32'h0000_0104; we = 0;
        step(); req = 0;
        step(); step(); step();
        step(); pready = 1; prdata = 32'hA5A5_5A5A;
        step(); pready = 0; prdata = 32'h0;
        #1 chk("tc rvalid", r_valid, 1'b1); chk("tc ropc", r_opc, 1'b0);
        chk("tc rdata", r_rdata, 32'hA5A5_5A5A);
        step();

        // Back-to-back reads with req held high
        step(); req = 1; add = 32'h0000_0020; we = 0;
        #1 chk("b2b gnt T", gnt, 1'b1);
        step(); add = 32'h0000_0024; pready = 1; prdata = 32'h1111_0001;
        #1 chk("b2b gnt T+1", gnt, 1'b0);
        step();
        #1 chk("b2b gnt T+2", gnt, 1'b0);
        step(); prdata = 32'h2222_0002;
        #1 chk("b2b gnt T+3", gnt, 1'b0); chk("b2b rdata1", r_rdata, 32'h1111_0001);
        step();
        #1 chk("b2b gnt T+4", gnt, 1'b1);
        step(); req = 0;
        step();
        #1 chk("b2b paddr2", paddr, 32'h0000_0024);
        step(); pready = 0; prdata = 32'h0;
        #1 chk("b2b rvalid2", r_valid, 1'b1); chk("b2b rdata2", r_rdata, 32'h2222_0002);
        step();

        // Async reset during ACCESS, then a clean write
        step(); req = 1; add = 32'h0000_0200; we = 1; wdata = 32'h0BAD_F00D; be = 4'h3;
        step(); req = 0;
        step();
        #1 chk("rst-mid penable before", penable, 1'b1);
        rst_n = 0;
        #1 chk("rst-mid psel", psel, 1'b0); chk("rst-mid penable", penable, 1'b0);
        chk("rst-mid paddr", paddr, 32'h0);
        step(); step(); step();
        rst_n = 1;
        step();
        step(); req = 1; add = 32'h0000_0040; we = 1; wdata = 32'h0000_55AA; be = 4'h3;
        step(); req = 0; pready = 1;
        step();
        #1 chk("post-rst pstrb", pstrb, 4'h3); chk("post-rst pwdata", pwdata, 32'h0000_55AA);
        step(); pready = 0;
        #1 chk("post-rst rvalid", r_valid, 1'b1); chk("post-rst ropc", r_opc, 1'b0);

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
